// File: rtl/data_memory_pkg.sv
// Shared declarations for the data-memory slice.
//   dmem_state_t    : init-sweep / ready state of the data memory
//   DMEM_WORD_BYTES : bytes per stored word
package utils_top;

  typedef enum logic {
    DMEM_INIT,
    DMEM_READY
  } dmem_state_t;

  localparam int unsigned DMEM_WORD_BYTES = 4;

endpackage

// File: rtl/dmem_init_fsm.sv
// Init-sweep controller for data_memory.
// After every reset it walks init_idx from 0 to DEPTH-1, one word per cycle,
// requesting a zero write for each, then settles in READY until the next reset.
// Ports:
//   clk, rst  : clock, asynchronous active-high reset
//   mem_busy  : 1 while the sweep is running
//   ready     : 1 once the sweep has finished
//   init_we   : sweep write request (zero to init_idx)
//   init_idx  : word currently being cleared
module dmem_init_fsm
  import utils_top::*;
#(
  parameter int unsigned DEPTH = 1024
) (
  input  logic                     clk,
  input  logic                     rst,
  output logic                     mem_busy,
  output logic                     ready,
  output logic                     init_we,
  output logic [$clog2(DEPTH)-1:0] init_idx
);

  localparam int unsigned IW = $clog2(DEPTH);
  localparam logic [IW-1:0] LAST_IDX = IW'(DEPTH - 1);

  dmem_state_t   state_q, state_d;
  logic [IW-1:0] idx_q, idx_d;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= DMEM_INIT;
      idx_q   <= '0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
    end
  end

  always_comb begin
    state_d  = state_q;
    idx_d    = idx_q;
    mem_busy = 1'b0;
    ready    = 1'b0;
    init_we  = 1'b0;
    unique case (state_q)
      DMEM_INIT: begin
        mem_busy = 1'b1;
        init_we  = 1'b1;
        if (idx_q == LAST_IDX) begin
          state_d = DMEM_READY;
        end else begin
          idx_d = idx_q + 1'b1;
        end
      end
      DMEM_READY: begin
        ready = 1'b1;
      end
      default: state_d = DMEM_INIT;
    endcase
  end

  assign init_idx = idx_q;

endmodule

// File: rtl/data_memory.sv
// Word-addressed data memory for the memory-access stage.
// Synchronous write, combinational read; a zero sweep runs after every reset
// and misaligned / out-of-range accesses raise a sticky error.
// Optional build macro: DATA_MEMORY_STATS_EN adds rd_cnt / wr_cnt counters.
// Ports:
//   clk, rst     : clock, asynchronous active-high reset
//   mem_cs       : access request
//   mem_wen      : 1 = store, 0 = load
//   mem_addr     : byte address
//   mem_dat_in   : store data
//   mem_dat_out  : load data (0 unless the access is accepted)
//   rd_cnt/wr_cnt: accepted read/write counts, saturating (stats build only)
//   mem_busy     : init sweep in progress
//   mem_err      : sticky access error
//   err_clr      : synchronous clear of mem_err
module data_memory
  import utils_top::*;
#(
  parameter int unsigned DEPTH     = 1024,
  parameter logic [31:0] BASE_ADDR = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        mem_cs,
  input  logic        mem_wen,
  input  logic [31:0] mem_addr,
  input  logic [31:0] mem_dat_in,
  output logic [31:0] mem_dat_out,
`ifdef DATA_MEMORY_STATS_EN
  output logic [31:0] rd_cnt,
  output logic [31:0] wr_cnt,
`endif
  output logic        mem_busy,
  output logic        mem_err,
  input  logic        err_clr
);

  localparam int unsigned IW = $clog2(DEPTH);
  // One bit wider than the address so DEPTH*4 == 2**32 would still compare correctly.
  localparam logic [32:0] SPAN = 33'(DEPTH) * 33'(DMEM_WORD_BYTES);

  logic          ready;
  logic          init_we;
  logic [IW-1:0] init_idx;

  dmem_init_fsm #(.DEPTH(DEPTH)) u_init_fsm (
    .clk      (clk),
    .rst      (rst),
    .mem_busy (mem_busy),
    .ready    (ready),
    .init_we  (init_we),
    .init_idx (init_idx)
  );

  logic [31:0]   offset;
  logic          addr_ok;
  logic [IW-1:0] idx;
  logic          access_ok;
  logic          access_bad;

  // Addresses below BASE_ADDR wrap to large offsets and fall out of range.
  assign offset     = mem_addr - BASE_ADDR;
  assign addr_ok    = (mem_addr[1:0] == 2'b00) && ({1'b0, offset} < SPAN);
  assign idx        = offset[IW+1:2];
  assign access_ok  = mem_cs && ready && addr_ok;
  assign access_bad = mem_cs && ready && !addr_ok;

  logic [31:0] mem_array [DEPTH];

  // Sweep and access writes never overlap: accesses require READY.
  logic          wr_en;
  logic [IW-1:0] wr_idx;
  logic [31:0]   wr_dat;

  always_comb begin
    wr_en  = 1'b0;
    wr_idx = idx;
    wr_dat = mem_dat_in;
    if (init_we) begin
      wr_en  = 1'b1;
      wr_idx = init_idx;
      wr_dat = '0;
    end else if (access_ok && mem_wen) begin
      wr_en = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (wr_en) begin
      mem_array[wr_idx] <= wr_dat;
    end
  end

  // Pre-edge contents, so a store shows the word it is about to replace.
  assign mem_dat_out = access_ok ? mem_array[idx] : '0;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      mem_err <= 1'b0;
    end else if (access_bad) begin
      mem_err <= 1'b1;
    end else if (err_clr) begin
      mem_err <= 1'b0;
    end
  end

`ifdef DATA_MEMORY_STATS_EN
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rd_cnt <= '0;
      wr_cnt <= '0;
    end else begin
      if (access_ok && !mem_wen && (rd_cnt != '1)) rd_cnt <= rd_cnt + 32'd1;
      if (access_ok &&  mem_wen && (wr_cnt != '1)) wr_cnt <= wr_cnt + 32'd1;
    end
  end
`endif

endmodule

// File: tb/tb_data_memory.sv
module tb_data_memory;

  localparam int unsigned DEPTH = 16;
  localparam logic [31:0] BASE  = 32'h0000_0000;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        mem_cs = 1'b0;
  logic        mem_wen = 1'b0;
  logic [31:0] mem_addr = '0;
  logic [31:0] mem_dat_in = '0;
  logic [31:0] mem_dat_out;
  logic        mem_busy;
  logic        mem_err;
  logic        err_clr = 1'b0;
`ifdef DATA_MEMORY_STATS_EN
  logic [31:0] rd_cnt;
  logic [31:0] wr_cnt;
`endif

  data_memory #(.DEPTH(DEPTH), .BASE_ADDR(BASE)) dut (
    .clk         (clk),
    .rst         (rst),
    .mem_cs      (mem_cs),
    .mem_wen     (mem_wen),
    .mem_addr    (mem_addr),
    .mem_dat_in  (mem_dat_in),
    .mem_dat_out (mem_dat_out),
`ifdef DATA_MEMORY_STATS_EN
    .rd_cnt      (rd_cnt),
    .wr_cnt      (wr_cnt),
`endif
    .mem_busy    (mem_busy),
    .mem_err     (mem_err),
    .err_clr     (err_clr)
  );

  always #5 clk = ~clk;

  int tests  = 0;
  int failed = 0;

  // Reference model: plain word array plus a count of remaining init cycles.
  logic [31:0] ref_mem [DEPTH];
  int          ref_init_left;
  logic        ref_err;
  int          ref_rd;
  int          ref_wr;

  typedef struct {
    logic        cs;
    logic        wen;
    logic        clr;
    logic [31:0] addr;
    logic [31:0] din;
    logic [31:0] exp_out;
    logic        exp_err;
  } vec_t;

  vec_t vecs[$];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      failed++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  function automatic logic addr_good(input logic [31:0] a);
    logic [31:0] off;
    off = a - BASE;
    return (a % 4 == 0) && (off < DEPTH * 4);
  endfunction

  // Called at posedge+1; applies inputs, checks outputs before the next edge,
  // then advances the model across that edge.
  task automatic cycle(input logic cs, input logic wen, input logic [31:0] addr,
                       input logic [31:0] din, input logic clr);
    logic        busy;
    logic        ok;
    logic [31:0] exp_out;
    mem_cs = cs; mem_wen = wen; mem_addr = addr; mem_dat_in = din; err_clr = clr;
    busy    = (ref_init_left > 0);
    ok      = cs && !busy && addr_good(addr);
    exp_out = ok ? ref_mem[(addr - BASE) / 4] : 32'h0;
    #4;
    chk("dat_out", mem_dat_out, exp_out);
    chk("busy", 32'(mem_busy), 32'(busy));
    chk("err", 32'(mem_err), 32'(ref_err));
`ifdef DATA_MEMORY_STATS_EN
    chk("rd_cnt", rd_cnt, 32'(ref_rd));
    chk("wr_cnt", wr_cnt, 32'(ref_wr));
`endif
    @(posedge clk);
    if (busy) ref_init_left--;
    if (ok && wen) ref_mem[(addr - BASE) / 4] = din;
    if (ok && wen) ref_wr++;
    if (ok && !wen) ref_rd++;
    if (cs && !busy && !addr_good(addr)) ref_err = 1'b1;
    else if (clr) ref_err = 1'b0;
    #1;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) cycle(1'b0, 1'b0, 32'h0, 32'h0, 1'b0);
  endtask

  // Asserted asynchronously, between clock edges.
  task automatic do_reset();
    #2;
    rst = 1'b1;
    mem_cs = 1'b1; mem_wen = 1'b0; mem_addr = 32'h0; err_clr = 1'b0;
    #1;
    chk("rst_busy", 32'(mem_busy), 32'h1);
    chk("rst_err", 32'(mem_err), 32'h0);
    chk("rst_out", mem_dat_out, 32'h0);
    @(posedge clk);
    #1;
    rst = 1'b0;
    mem_cs = 1'b0;
    foreach (ref_mem[i]) ref_mem[i] = 32'h0;
    ref_init_left = DEPTH;
    ref_err = 1'b0;
    ref_rd = 0;
    ref_wr = 0;
  endtask

  function automatic void add(input logic cs, input logic wen, input logic clr,
                              input logic [31:0] addr, input logic [31:0] din,
                              input logic [31:0] exp_out, input logic exp_err);
    vec_t v;
    v.cs = cs; v.wen = wen; v.clr = clr; v.addr = addr; v.din = din;
    v.exp_out = exp_out; v.exp_err = exp_err;
    vecs.push_back(v);
  endfunction

  initial begin
    // Directed table, applied right after the first sweep (array all zero).
    add(1, 0, 0, 32'h3C, 32'h0,         32'h0,         0);
    add(1, 1, 0, 32'h08, 32'hDEAD_BEEF, 32'h0,         0);
    add(1, 0, 0, 32'h08, 32'h0,         32'hDEAD_BEEF, 0);
    add(1, 0, 0, 32'h0C, 32'h0,         32'h0,         0);
    add(1, 1, 0, 32'h10, 32'h1111_1111, 32'h0,         0);
    add(1, 1, 0, 32'h10, 32'h2222_2222, 32'h1111_1111, 0);
    add(1, 0, 0, 32'h10, 32'h0,         32'h2222_2222, 0);
    add(1, 1, 0, 32'h06, 32'hAAAA_AAAA, 32'h0,         0);
    add(1, 0, 1, 32'h40, 32'h0,         32'h0,         1);
    add(1, 0, 0, 32'h04, 32'h0,         32'h0,         1);
    add(0, 0, 1, 32'h00, 32'h0,         32'h0,         1);
    add(0, 0, 0, 32'h00, 32'h0,         32'h0,         0);
    add(1, 0, 0, 32'hFFFF_FFFC, 32'h0,  32'h0,         0);
    add(0, 0, 1, 32'h00, 32'h0,         32'h0,         1);
    add(0, 0, 0, 32'h00, 32'h0,         32'h0,         0);
    add(1, 1, 0, 32'h3C, 32'h1234_5678, 32'h0,         0);
    add(1, 0, 0, 32'h3C, 32'h0,         32'h1234_5678, 0);
    add(1, 0, 0, 32'h00, 32'h0,         32'h0,         0);

    rst = 1'b1;
    #1;
    chk("por_busy", 32'(mem_busy), 32'h1);
    chk("por_err", 32'(mem_err), 32'h0);
    chk("por_out", mem_dat_out, 32'h0);
    do_reset();
    idle(DEPTH);

    for (int i = 0; i < vecs.size(); i++) begin
      mem_cs = vecs[i].cs; mem_wen = vecs[i].wen; mem_addr = vecs[i].addr;
      #2;
      chk("vec_out", mem_dat_out, vecs[i].exp_out);
      chk("vec_err", 32'(mem_err), 32'(vecs[i].exp_err));
      #1;
      cycle(vecs[i].cs, vecs[i].wen, vecs[i].addr, vecs[i].din, vecs[i].clr);
    end

    // Mid-sweep reset: the second sweep restarts and clears the earlier store.
    cycle(1'b1, 1'b1, 32'h04, 32'h5, 1'b0);
    cycle(1'b1, 1'b0, 32'h04, 32'h0, 1'b0);
    do_reset();
    idle(5);
    do_reset();
    cycle(1'b1, 1'b1, 32'h04, 32'hFFFF_FFFF, 1'b0);
    cycle(1'b1, 1'b1, 32'h44, 32'hFFFF_FFFF, 1'b0);
    idle(DEPTH - 2);
    chk("sweep_done", 32'(mem_busy), 32'h0);
    cycle(1'b1, 1'b0, 32'h04, 32'h0, 1'b0);
    chk("init_write_ignored_err", 32'(mem_err), 32'h0);

`ifdef DATA_MEMORY_STATS_EN
    do_reset();
    idle(DEPTH);
    cycle(1'b1, 1'b0, 32'h00, 32'h0, 1'b0);
    cycle(1'b1, 1'b1, 32'h08, 32'h7, 1'b0);
    cycle(1'b1, 1'b0, 32'h08, 32'h0, 1'b0);
    cycle(1'b1, 1'b0, 32'h41, 32'h0, 1'b0);
    cycle(1'b1, 1'b1, 32'h0C, 32'h9, 1'b0);
    cycle(1'b1, 1'b0, 32'h0C, 32'h0, 1'b0);
    chk("stats_rd", rd_cnt, 32'd3);
    chk("stats_wr", wr_cnt, 32'd2);
`endif

    // Random traffic against the model.
    for (int i = 0; i < 400; i++) begin
      logic [31:0] a;
      int unsigned kind;
      kind = $urandom_range(0, 9);
      if (kind == 0)      a = BASE + 32'($urandom_range(0, DEPTH * 4 - 1)) | 32'h1;
      else if (kind == 1) a = BASE + 32'(DEPTH * 4) + 32'($urandom_range(0, 255)) * 4;
      else                a = BASE + 32'($urandom_range(0, DEPTH - 1)) * 4;
      cycle(1'($urandom_range(0, 3) != 0), 1'($urandom_range(0, 1)), a,
            $urandom, 1'($urandom_range(0, 3) == 0));
      if (i == 200) begin
        do_reset();
      end
    end

    $display("[TB] %0d tests run, %0d failed", tests, failed);
    $finish;
  end

  initial begin
    #2_000_000;
    failed++;
    $display("FAIL timeout: got running, expected finished");
    $display("[TB] %0d tests run, %0d failed", tests, failed);
    $fatal(1);
  end

endmodule
